multicycle_controller: RTL and testbench

- Main control FSM of the multicycle MIPS datapath.
- Decodes opcode from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath enables, plus the 2-bit alu_op consumed by the downstream ALU controller (00 memory/add, 01 branch/sub, 10 R-type/func-decoded, 11 jump/off).
- Single shared instruction/data memory with a ready handshake.

---
 rtl/multicycle_controller.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters are enabled by defining CTRL_PERF_COUNTERS_EN.
module multicycle_controller #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_instr
`ifdef CTRL_PERF_COUNTERS_EN
  ,
  output logic [31:0]         retired_count,
  output logic [31:0]         stall_count
`endif
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(2'b00);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2'b01);
  localparam logic [ALU_OP_W-1:0] ALU_FUNC = ALU_OP_W'(2'b10);
  localparam logic [ALU_OP_W-1:0] ALU_OFF  = ALU_OP_W'(2'b11);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    ADDI_EXEC = 4'd8,
    ADDI_WB   = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    ILLEGAL   = 4'd12
  } state_t;

  state_t state, state_next;

  // The zero flag is ANDed with pc_write_cond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:     state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_R:         state_next = R_EXEC;
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDI_EXEC;
          OP_J:         state_next = JUMP;
          default:      state_next = ILLEGAL;
        endcase
      end
      // An opcode that is neither LW nor SW here must never start a memory access.
      MEM_ADDR: begin
        if (opcode == OP_LW)      state_next = MEM_READ;
        else if (opcode == OP_SW) state_next = MEM_WRITE;
        else                      state_next = FETCH;
      end
      MEM_READ:  state_next = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_next = mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_next = R_WB;
      ADDI_EXEC: state_next = ADDI_WB;
      default:   state_next = FETCH;
    endcase
  end

  // Outputs are gated by rst so that nothing is driven, even FETCH's read, while reset is held.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    alu_op        = ALU_ADD;
    illegal_instr = 1'b0;
    if (rst) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:    alu_src_b = 2'b11;
        MEM_ADDR, ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNC;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ADDI_WB:   reg_write = 1'b1;
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
          alu_op   = ALU_OFF;
        end
        ILLEGAL:   illegal_instr = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_count <= 32'd0;
      stall_count   <= 32'd0;
    end else begin
      if (state_next == FETCH && state != FETCH && state != ILLEGAL)
        retired_count <= retired_count + 32'd1;
      if ((state == FETCH || state == MEM_READ || state == MEM_WRITE) && !mem_ready)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; counter checks run when CTRL_PERF_COUNTERS_EN is defined.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_instr;
  logic [1:0] alu_src_b, pc_src, alu_op;
`ifdef CTRL_PERF_COUNTERS_EN
  logic [31:0] retired_count, stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b[2], pc_src[2], alu_op[2], illegal_instr}
  localparam logic [16:0] E_OFF       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FETCH_STL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_ADDR      = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEM_READ  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEM_WB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_MEM_WRITE = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_R_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
  localparam logic [16:0] E_R_WB      = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_ADDI_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] E_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_10_11_0;
  localparam logic [16:0] E_ILLEGAL   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  logic [16:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal_instr};

  multicycle_controller #(.OPCODE_W(6), .ALU_OP_W(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .alu_op(alu_op), .illegal_instr(illegal_instr)
`ifdef CTRL_PERF_COUNTERS_EN
    , .retired_count(retired_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    logic [16:0] exp_seq [6];
    exp_seq = '{E_OFF, E_FETCH_RDY, E_DECODE, E_R_EXEC, E_OFF, E_OFF};
    opcode = OP_R;
    mem_ready = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        repeat (2) @(negedge clk);
      end else if (i == 1) begin
        rst = 1'b1;
      end else if (i == 4) begin
        #2 rst = 1'b0;
      end else begin
        @(negedge clk);
      end
      #1;
      vectors++;
      if (ctrl !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL reset step %0d: ctrl=%b expected %b", i, ctrl, exp_seq[i]);
      end
    end
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (ctrl !== E_FETCH_STL) begin
      miscompares++;
      $display("[TB] FAIL reset_release_fetch: ctrl=%b expected %b", ctrl, E_FETCH_STL);
    end
  endtask

  task automatic test_r_type;
    logic [16:0] exp_seq [5];
    exp_seq = '{E_FETCH_RDY, E_DECODE, E_R_EXEC, E_R_WB, E_FETCH_RDY};
    opcode = OP_R;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = 1'b1;
      #1;
      vectors++;
      if (ctrl !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL r_type cycle %0d: ctrl=%b expected %b", i, ctrl, exp_seq[i]);
      end
    end
  endtask

  task automatic test_lw_wait;
    logic [16:0] exp_seq [8];
    logic        rdy_seq [8];
    exp_seq = '{E_FETCH_RDY, E_DECODE, E_ADDR, E_MEM_READ, E_MEM_READ, E_MEM_READ,
                E_MEM_WB, E_FETCH_RDY};
    rdy_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = OP_LW;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy_seq[i];
      #1;
      vectors++;
      if (ctrl !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL lw_wait cycle %0d: ctrl=%b expected %b", i, ctrl, exp_seq[i]);
      end
    end
  endtask

  task automatic test_sw_stall;
    logic [16:0] exp_seq [7];
    logic        rdy_seq [7];
    exp_seq = '{E_FETCH_STL, E_FETCH_RDY, E_DECODE, E_ADDR, E_MEM_WRITE, E_MEM_WRITE, E_FETCH_RDY};
    rdy_seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    opcode = OP_SW;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = rdy_seq[i];
      #1;
      vectors++;
      if (ctrl !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL sw_stall cycle %0d: ctrl=%b expected %b", i, ctrl, exp_seq[i]);
      end
    end
  endtask

  task automatic test_branch;
    logic [16:0] exp_seq [4];
    exp_seq = '{E_FETCH_RDY, E_DECODE, E_BRANCH, E_FETCH_RDY};
    opcode = OP_BEQ;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        mem_ready = 1'b1;
        #1;
        vectors++;
        if (ctrl !== exp_seq[i]) begin
          miscompares++;
          $display("[TB] FAIL branch zero=%0d cycle %0d: ctrl=%b expected %b",
                   z, i, ctrl, exp_seq[i]);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal;
    logic [16:0] exp_seq [6];
    exp_seq = '{E_FETCH_RDY, E_DECODE, E_ILLEGAL, E_FETCH_RDY, E_DECODE, E_R_EXEC};
    opcode = OP_BAD;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = 1'b1;
      if (i == 3) opcode = OP_R;
      #1;
      vectors++;
      if (ctrl !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL illegal cycle %0d: ctrl=%b expected %b", i, ctrl, exp_seq[i]);
      end
    end
    @(negedge clk);
    #1;
    vectors++;
    if (ctrl !== E_R_WB) begin
      miscompares++;
      $display("[TB] FAIL illegal_recover_wb: ctrl=%b expected %b", ctrl, E_R_WB);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp_seq [8];
    logic [5:0]  op_seq  [8];
    exp_seq = '{E_FETCH_RDY, E_DECODE, E_ADDR, E_ADDI_WB, E_FETCH_RDY, E_DECODE, E_JUMP, E_FETCH_RDY};
    op_seq  = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_J, OP_J, OP_J, OP_J};
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = 1'b1;
      opcode = op_seq[i];
      #1;
      vectors++;
      if (ctrl !== exp_seq[i]) begin
        miscompares++;
        $display("[TB] FAIL back_to_back cycle %0d: ctrl=%b expected %b", i, ctrl, exp_seq[i]);
      end
    end
  endtask

`ifdef CTRL_PERF_COUNTERS_EN
  task automatic test_perf_counters;
    logic [5:0] op_seq [4];
    op_seq = '{OP_J, OP_BAD, OP_BEQ, OP_J};
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    vectors++;
    if (retired_count !== 32'd0 || stall_count !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL perf_reset: retired=%0d stall=%0d expected 0 0", retired_count, stall_count);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opcode = op_seq[k];
      repeat (3) @(negedge clk);
    end
    #1;
    vectors++;
    if (retired_count !== 32'd3 || stall_count !== 32'd2) begin
      miscompares++;
      $display("[TB] FAIL perf_counts: retired=%0d stall=%0d expected 3 2", retired_count, stall_count);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting multicycle_controller bench");
    test_reset();
    test_r_type();
    test_lw_wait();
    test_sw_stall();
    test_branch();
    test_illegal();
    test_back_to_back();
`ifdef CTRL_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
